// File: rtl/seq_mul_pkg.sv
// Shared encodings for the sequential RV32M multiplier: op codes, FSM states
// and the iteration-counter width helper.
package seq_mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    // One extra bit so the counter can also hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// Ripple-carry adder built from the full-adder cell; shared by the multiply
// accumulate step and the two's-complement fix-up of the product.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_adder_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with start/busy/done.
// Optional early exit from CALC when SEQ_MUL_EARLY_TERM_EN is defined.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);
    // Handshake: start is sampled only in IDLE or DONE; busy is high in CALC
    // and SIGN; done is a one-cycle pulse and result holds until next accept.

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] prod;        // {accumulator, multiplier}
    logic [WIDTH-1:0]   mcand;
    logic [1:0]         op_q;
    logic               neg_a_q, neg_b_q;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               signed_a, signed_b, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH-1:0]   lo_a, lo_b, lo_sum, hi_sum;
    logic               lo_cin, lo_cout, hi_cout_unused;
    logic [2*WIDTH-1:0] aligned, fixed, step;
    logic [WIDTH-1:0]   result_nx;

    assign accept   = start && (state == IDLE || state == DONE);
    assign signed_a = (op == OP_MULH) || (op == OP_MULHSU);
    assign signed_b = (op == OP_MULH);
    assign neg_a    = signed_a & a[WIDTH-1];
    assign neg_b    = signed_b & b[WIDTH-1];
    // Unsigned WIDTH-bit magnitude keeps 2^(WIDTH-1) representable.
    assign mag_a    = neg_a ? (~a + ONE) : a;
    assign mag_b    = neg_b ? (~b + ONE) : b;

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             rem_zero;
    logic [CW-1:0]    shamt;

    // Multiplier bits still to be consumed after this cycle's shift.
    assign rem_mask = ({WIDTH{1'b1}} >> cnt) >> 1;
    assign rem_zero = ((prod[WIDTH-1:0] >> 1) & rem_mask) == '0;
    // cnt wraps to 0 after a full run, meaning no alignment is needed.
    assign shamt    = (cnt == '0) ? '0 : (CW'(WIDTH) - cnt);
    assign aligned  = prod >> shamt;
`else
    assign aligned  = prod;
`endif

    always_comb begin
        lo_a   = prod[2*WIDTH-1:WIDTH];
        lo_b   = prod[0] ? mcand : '0;
        lo_cin = 1'b0;
        if (state == SIGN) begin
            lo_a   = ~aligned[WIDTH-1:0];
            lo_b   = '0;
            lo_cin = 1'b1;
        end
    end

    ripple_adder_n #(.WIDTH(WIDTH)) u_add_lo (
        .a    (lo_a),
        .b    (lo_b),
        .cin  (lo_cin),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    ripple_adder_n #(.WIDTH(WIDTH)) u_add_hi (
        .a    (~aligned[2*WIDTH-1:WIDTH]),
        .b    ({WIDTH{1'b0}}),
        .cin  (lo_cout),
        .sum  (hi_sum),
        .cout (hi_cout_unused)
    );

    // Carry-out lands in the accumulator MSB as the register shifts right.
    assign step      = {lo_cout, lo_sum, prod[WIDTH-1:1]};
    assign fixed     = (neg_a_q ^ neg_b_q) ? {hi_sum, lo_sum} : aligned;
    assign result_nx = (op_q == OP_MUL) ? fixed[WIDTH-1:0] : fixed[2*WIDTH-1:WIDTH];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) state_nx = SIGN;
`ifdef SEQ_MUL_EARLY_TERM_EN
                else if (rem_zero) state_nx = SIGN;
`endif
            end
            SIGN: state_nx = DONE;
            DONE: state_nx = start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prod    <= '0;
            mcand   <= '0;
            op_q    <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q    <= op;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                mcand   <= mag_a;
                prod    <= {{WIDTH{1'b0}}, mag_b};
                cnt     <= '0;
            end else if (state == CALC) begin
                prod <= step;
                cnt  <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + CW'(1);
            end else if (state == SIGN) begin
                result <= result_nx;
            end
        end
    end

    assign busy      = (state == CALC) || (state == SIGN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed scoreboard bench for seq_multiplier (WIDTH=32): results, latency,
// busy length, ignored starts, back-to-back issue and mid-operation reset.
module tb_seq_multiplier;
    import seq_mul_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           iss_q[$];
    int           etl_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int           busy_cnt = 0;
    int           mon_lat, mon_iss, mon_etl;
    logic [W-1:0] mon_exp;

    always @(negedge clk) begin
        if (dbg_state == IDLE) busy_cnt = 0;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_iss = iss_q.pop_front();
                mon_etl = etl_q.pop_front();
                mon_lat = cyc - mon_iss;
                check("result", result, mon_exp);
`ifdef SEQ_MUL_EARLY_TERM_EN
                if (mon_etl != 0) check("latency", W'(mon_lat), W'(mon_etl));
                else check("latency_range", W'(mon_lat >= 3 && mon_lat <= W + 2), 1);
                check("busy_cycles", W'(busy_cnt), W'(mon_lat - 1));
`else
                check("latency", W'(mon_lat), W'(W + 2));
                check("busy_cycles", W'(busy_cnt), W'(W + 1));
`endif
            end
            busy_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input int etl);
        int guard = 0;
        @(negedge clk);
        while (!(dbg_state == IDLE || dbg_state == DONE) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("issue_timeout", 1, 0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(r);
        iss_q.push_back(cyc);
        etl_q.push_back(etl);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic stray_start();
        start = 1'b1;
        op    = OP_MULHU;
        a     = 32'hFFFF_FFFF;
        b     = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           etl;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   W'(busy), 0);
        check("rst_done",   W'(done), 0);
        check("rst_result", result, 0);
        check("rst_state",  W'(dbg_state), W'(IDLE));
        rst = 1'b0;

        vecs.push_back('{OP_MUL,    32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 0});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0});
        vecs.push_back('{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0});
        vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0});
        vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0});
        vecs.push_back('{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back('{OP_MULH,   32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0});
        vecs.push_back('{OP_MUL,    32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 0});
        vecs.push_back('{OP_MULHU,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0});
        vecs.push_back('{OP_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 0});
        vecs.push_back('{OP_MUL,    32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 3});

        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].etl);

        // Starts while busy must be ignored; the next issue lands in the DONE cycle.
        issue(OP_MUL, 32'h0000_0007, 32'h8000_0006, 32'h8000_002A, 0);
        repeat (3) @(negedge clk);
        stray_start();
        repeat (14) @(negedge clk);
        stray_start();
        issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0);

        // Reset in the middle of CALC abandons the operation.
        issue(OP_MUL, 32'h0000_FFFF, 32'h8000_0001, 32'h0000_0000, 0);
        void'(exp_q.pop_back());
        void'(iss_q.pop_back());
        void'(etl_q.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",   W'(busy), 0);
        check("midrst_done",   W'(done), 0);
        check("midrst_result", result, 0);
        check("midrst_state",  W'(dbg_state), W'(IDLE));
        rst = 1'b0;
        issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", W'(exp_q.size()), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Iterative shift-add multiplier for the RV32M multiply ops (MUL, MULH, MULHSU, MULHU). It is the parametrised, sequential successor to the team's ripple-carry adder: one WIDTH-bit ripple add per cycle replaces a large combinational array. It sits beside the ALU in the execute stage and uses a start/busy/done handshake toward the core's stall logic.

Parameters:
WIDTH, 32, operand and result width in bits; must be at least 2.

Ports:
clk  in  1  Single clock; all state updates on the rising edge.
rst  in  1  Synchronous, active-high reset.
start  in  1  Request a multiply. Sampled only in IDLE or DONE.
op  in  2  Operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
a  in  WIDTH  Multiplicand (rs1). Signed for MULH/MULHSU.
b  in  WIDTH  Multiplier (rs2). Signed for MULH only.
busy  out  1  High while in CALC or SIGN.
done  out  1  One-cycle pulse; result valid that cycle.
result  out  WIDTH  Low half of product for MUL, high half otherwise. Held until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - Go to IDLE.
  - busy=0, done=0, result=0; all internal registers cleared.
- FSM states and transitions:
  - IDLE: go to CALC when start=1.
  - CALC: runs exactly WIDTH cycles, then goes to SIGN.
  - SIGN: one cycle, then goes to DONE.
  - DONE: done=1. Go to CALC if start=1 (back-to-back issue), else IDLE.
- Acceptance: on the edge where start is accepted, latch op, the sign flags, |a| and |b| (magnitude per op signedness), and clear the 2*WIDTH product register and the counter.
- CALC step, per cycle:
  - If the multiplier LSB is 1, the upper accumulator is replaced by a WIDTH-bit add of upper accumulator + multiplicand; carry-out is kept as bit WIDTH.
  - The {carry, accumulator, multiplier} register then shifts right by 1.
  - The counter increments and wraps at WIDTH.
- SIGN: if neg_a XOR neg_b, negate the 2*WIDTH product (two's complement). Then register result from the low or high half according to op.
- Latency: done asserts exactly WIDTH+2 cycles after the cycle in which start was accepted (34 for WIDTH=32).
- Handshake rules:
  - start while busy=1 is ignored (no queueing) and has no effect on the op in flight.
  - a, b and op need only be stable in the cycle start is accepted.
- Boundary cases:
  - The most-negative operand (0x80000000) has magnitude 2^(WIDTH-1); this must be representable, so magnitudes are held as unsigned WIDTH bits.
  - A zero operand still takes the full latency.
  - MUL result is independent of signedness.

Optional Feature:
Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined:
  - CALC exits to SIGN early when the remaining unshifted multiplier bits are all zero.
  - The product is aligned by one extra shift of the remaining count, done inside SIGN.
  - Latency becomes variable, between 3 and WIDTH+2 cycles; results are identical.
  - busy/done semantics are unchanged.
- Undefined: fixed latency of WIDTH+2 cycles; no early-exit logic is synthesised.

Decomposition:
- Package seq_mul_pkg holds:
  - op encodings OP_MUL=2'b00, OP_MULH=2'b01, OP_MULHSU=2'b10, OP_MULHU=2'b11;
  - FSM state encoding IDLE/CALC/SIGN/DONE;
  - a helper constant for counter width, $clog2(WIDTH)+1.
- One sub-module, ripple_adder_n: a parametrised WIDTH-bit ripple-carry adder (A, B, Cin, sum, Cout), built from the team's existing full-adder cell. It is instanced once for the CALC accumulate. The SIGN negation reuses it via inversion with Cin=1, applied per half with the carry chained.

Test Plan:
1. op=MUL, a=7, b=6, start pulsed 1 cycle -> busy=1 for 33 cycles, done pulses at cycle 34, result=0x0000002A.
2. a=0xFFFFFFFF, b=0xFFFFFFFF: op=MULH -> result=0x00000000; op=MULHU -> 0xFFFFFFFE; op=MUL -> 0x00000001.
3. op=MULHSU, a=0xFFFFFFFF (-1), b=2 -> result=0xFFFFFFFF. Then op=MULH, a=b=0x80000000 -> result=0x40000000.
4. Pulse start again at cycles 5 and 20 of an operation -> ignored; first result unchanged. Start asserted in the DONE cycle -> next op begins, done again WIDTH+2 later.
5. rst=1 at cycle 10 of CALC -> next cycle busy=0, done=0, result=0, state IDLE. A fresh MUL 3*5 then returns 0x0000000F.
6. With SEQ_MUL_EARLY_TERM_EN defined: MUL a=0x12345678, b=1 -> done at cycle 3, result=0x12345678. Random signed/unsigned regression against a golden 64-bit model for all four ops.
